mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
Multicycle MIPS control unit. It drives every control input of the multicycle datapath and consumes the datapath's opcode, funct and zero outputs. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback, one state per clock. It also drives memory enables and the IR/PC write strobes.

Parameters:
RESET_PC_WAIT, 1, number of IDLE cycles after reset release before the first FETCH (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
opcode  input  6  IR[31:26] from datapath
func  input  6  IR[5:0] from datapath
zero  input  1  ALU zero flag from datapath
mem_ready  input  1  memory access complete (used only with MC_MEM_WAIT_EN)
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if branch condition met (resolved internally; see Behaviour)
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable
ir_write  output  1  IR load
reg_dst  output  2  00 = rt, 01 = rd, 10 = $31
data_to_write  output  2  00 = ALUOut, 01 = MDR, 10 = PC
mem_to_reg  output  1  equals data_to_write == 01
alu_src_a  output  1  0 = PC, 1 = A register
alu_src  output  2  ALU B: 00 = B, 01 = const 4, 10 = sign-ext, 11 = sign-ext << 2
alu_ctrl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  output  1  0 = ALU result, 1 = ALUOut
jmp  output  1  PC <= {PC[31:28], IR[25:0], 00}
jr  output  1  PC <= A register
reg_write  output  1  register file write
instr_done  output  1  one-cycle pulse in the last state of each instruction
illegal  output  1  sticky: unsupported opcode/funct decoded

Behaviour:
- Reset (rst low, async): state = IDLE; all outputs 0; illegal = 0; wait counter = RESET_PC_WAIT.
- IDLE: all outputs 0. Move to FETCH after RESET_PC_WAIT cycles.
- FETCH: i_or_d=0, mem_read=1, ir_write=1, alu_src_a=0, alu_src=01, alu_ctrl=010, pc_src=0, pc_write=1. Next state DECODE.
- DECODE: alu_src_a=0, alu_src=11, alu_ctrl=010 (branch target into ALUOut). Next state by opcode:
  - 000000 with func 001000 (jr) -> JR; other R-type -> RTYPE_EX
  - 100011 lw / 101011 sw -> MEM_ADDR
  - 000100 beq / 000101 bne -> BRANCH
  - 001000 addi / 001010 slti -> IMM_EX
  - 000010 j -> JUMP; 000011 jal -> JAL
  - anything else -> FETCH, with illegal set to 1.
- RTYPE_EX: alu_src_a=1, alu_src=00, alu_ctrl from func: 100000 add -> 010, 100010 sub -> 110, 100100 and -> 000, 100101 or -> 001, 101010 slt -> 111. Any other func -> FETCH and set illegal.
- RTYPE_WB: reg_dst=01, data_to_write=00, reg_write=1, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src=10, alu_ctrl=010 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: i_or_d=1, mem_read=1 -> MEM_WB.
- MEM_WB: reg_dst=00, data_to_write=01, reg_write=1, instr_done=1 -> FETCH.
- MEM_WR: i_or_d=1, mem_write=1, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src=00, alu_ctrl=110, pc_src=1, pc_write_cond=1, instr_done=1 -> FETCH.
  - Effective PC load = pc_write_cond & (zero XOR is_bne).
  - is_bne is latched from opcode in DECODE.
- IMM_EX: alu_src_a=1, alu_src=10, alu_ctrl=010 (addi) or 111 (slti) -> IMM_WB.
- IMM_WB: reg_dst=00, data_to_write=00, reg_write=1, instr_done=1 -> FETCH.
- JUMP: jmp=1, pc_write=1, instr_done=1 -> FETCH.
- JAL: jmp=1, pc_write=1, reg_dst=10, data_to_write=10, reg_write=1, instr_done=1 -> FETCH. The register file captures PC (already PC+4) in the same edge the PC is overwritten.
- JR: jr=1, pc_write=1, instr_done=1 -> FETCH.
- Cycle counts: beq/bne/j/jal/jr = 3, sw/R-type/addi/slti = 4, lw = 5.
- Unassigned outputs in each state are 0. No unused state encodings are reachable; any illegal encoding returns to IDLE.
- Reset mid-instruction aborts immediately; no write strobes are asserted during or after reset until FETCH.
- illegal clears only on reset.

Optional Feature:
MC_MEM_WAIT_EN.
- Defined: FETCH, MEM_RD and MEM_WR hold their outputs and state until mem_ready=1. pc_write and ir_write in FETCH are asserted only in the cycle mem_ready=1.
- Undefined: mem_ready is ignored and memory is single-cycle.

Decomposition:
Package mips_mc_pkg holds:
- state enum
- opcode and funct localparams
- ALU control codes
- mux select codes for reg_dst, data_to_write and alu_src

One sub-module, mips_alu_decoder: combinational func -> alu_ctrl with a legal flag, shared with the single-cycle design.

Test Plan:
- Reset release, RESET_PC_WAIT=1: one IDLE cycle, then FETCH with mem_read=1, ir_write=1, pc_write=1, alu_src=01, alu_ctrl=010.
- add (opcode 000000, func 100000): states FETCH, DECODE, RTYPE_EX (alu_ctrl=010), RTYPE_WB (reg_dst=01, reg_write=1, instr_done=1), 4 cycles total.
- lw (100011): 5 cycles; MEM_RD has i_or_d=1, mem_read=1; MEM_WB has data_to_write=01, mem_to_reg=1.
- Branches:
  - beq with zero=1 -> effective PC load asserted in BRANCH.
  - bne (000101) with zero=1 -> no PC load.
  - bne with zero=0 -> PC load.
- jal (000011): JAL cycle has jmp=1, pc_write=1, reg_dst=10, data_to_write=10, reg_write=1. Opcode 111111 -> back to FETCH after DECODE, illegal=1 and still 1 after the next instruction.
- With MC_MEM_WAIT_EN: hold mem_ready=0 for 3 cycles in FETCH -> state unchanged, pc_write=0; mem_ready=1 -> pc_write=1, then DECODE. Also assert rst low during MEM_WR -> mem_write drops to 0 asynchronously.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// States, opcode/funct codes, ALU control codes and datapath mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RTYPE_EX, S_RTYPE_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_BRANCH, S_IMM_EX, S_IMM_WB, S_JUMP, S_JAL, S_JR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] DTW_ALUOUT = 2'b00;
  localparam logic [1:0] DTW_MDR    = 2'b01;
  localparam logic [1:0] DTW_PC     = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control/status bundle between the multicycle controller (master) and datapath (slave).
// The master consumes IR fields, zero and mem_ready, and drives every control strobe.
interface mips_mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] data_to_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src;
  logic [2:0] alu_ctrl;
  logic       pc_src;
  logic       jmp;
  logic       jr;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, func, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           data_to_write, mem_to_reg, alu_src_a, alu_src, alu_ctrl, pc_src, jmp, jr,
           reg_write, instr_done, illegal
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
           data_to_write, mem_to_reg, alu_src_a, alu_src, alu_ctrl, pc_src, jmp, jr,
           reg_write, instr_done, illegal
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational R-type funct -> ALU control decode with a legal flag.
// Unsupported funct yields alu_ctrl 000 and legal 0.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = 3'b000;
    legal    = 1'b1;
    case (func)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath, one state per clock.
// Optional MC_MEM_WAIT_EN: FETCH/MEM_RD/MEM_WR stall until mem_ready; otherwise memory is single-cycle.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int unsigned RESET_PC_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_mc_controller_if.master  bus
);

  localparam logic [3:0] WAIT_INIT = 4'(RESET_PC_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       is_bne_q, is_bne_d;
  logic       illegal_q, illegal_d;
  logic [2:0] fn_alu_ctrl;
  logic       fn_legal;
  logic       mem_ok;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok           = 1'b1;
`endif

  mips_alu_decoder u_alu_dec (
    .func     (bus.func),
    .alu_ctrl (fn_alu_ctrl),
    .legal    (fn_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= WAIT_INIT;
      is_bne_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_bne_q  <= is_bne_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal    = illegal_q;
  assign bus.mem_to_reg = (bus.data_to_write == DTW_MDR);

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    is_bne_d          = is_bne_q;
    illegal_d         = illegal_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = REGDST_RT;
    bus.data_to_write = DTW_ALUOUT;
    bus.alu_src_a     = 1'b0;
    bus.alu_src       = SRCB_B;
    bus.alu_ctrl      = 3'b000;
    bus.pc_src        = 1'b0;
    bus.jmp           = 1'b0;
    bus.jr            = 1'b0;
    bus.reg_write     = 1'b0;
    bus.instr_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.alu_src  = SRCB_FOUR;
        bus.alu_ctrl = ALU_ADD;
        if (mem_ok) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures the branch target speculatively.
        bus.alu_src  = SRCB_IMM_SH2;
        bus.alu_ctrl = ALU_ADD;
        is_bne_d     = (bus.opcode == OP_BNE);
        case (bus.opcode)
          OP_RTYPE:       state_d = (bus.func == FN_JR) ? S_JR : S_RTYPE_EX;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IMM_EX;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_RTYPE_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = fn_alu_ctrl;
        state_d       = fn_legal ? S_RTYPE_WB : S_FETCH;
        if (!fn_legal) illegal_d = 1'b1;
      end
      S_RTYPE_WB: begin
        bus.reg_dst    = REGDST_RD;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src   = SRCB_IMM;
        bus.alu_ctrl  = ALU_ADD;
        state_d       = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.i_or_d   = 1'b1;
        bus.mem_read = 1'b1;
        if (mem_ok) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.data_to_write = DTW_MDR;
        bus.reg_write     = 1'b1;
        bus.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEM_WR: begin
        bus.i_or_d    = 1'b1;
        bus.mem_write = 1'b1;
        if (mem_ok) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_BRANCH: begin
        // Branch sense resolved here so the datapath sees a single PC-load qualifier.
        bus.alu_src_a     = 1'b1;
        bus.alu_ctrl      = ALU_SUB;
        bus.pc_src        = 1'b1;
        bus.pc_write_cond = bus.zero ^ is_bne_q;
        bus.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end
      S_IMM_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src   = SRCB_IMM;
        bus.alu_ctrl  = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d       = S_IMM_WB;
      end
      S_IMM_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        bus.jmp        = 1'b1;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_JAL: begin
        bus.jmp           = 1'b1;
        bus.pc_write      = 1'b1;
        bus.reg_dst       = REGDST_RA;
        bus.data_to_write = DTW_PC;
        bus.reg_write     = 1'b1;
        bus.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end
      S_JR: begin
        bus.jr         = 1'b1;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = WAIT_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle expected control words queued by the
// stimulus process and compared on the falling edge by an independent monitor.
module tb_mips_mc_controller;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] data_to_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src;
    logic [2:0] alu_ctrl;
    logic       pc_src;
    logic       jmp;
    logic       jr;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  localparam int T_IDLE = 0, T_FETCH = 1, T_DEC = 2, T_REX = 3, T_RWB = 4, T_MADDR = 5;
  localparam int T_MRD = 6, T_MWB = 7, T_MWR = 8, T_BR = 9, T_IEX = 10, T_IWB = 11;
  localparam int T_J = 12, T_JAL = 13, T_JR = 14, T_FWAIT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic ill_exp = 1'b0;
  ctl_t sb[$];
  string tq[$];
  ctl_t obs;

  mips_mc_controller_if bus ();

  mips_mc_controller #(.RESET_PC_WAIT(1)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.data_to_write, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src, bus.alu_ctrl, bus.pc_src, bus.jmp, bus.jr, bus.reg_write,
                bus.instr_done, bus.illegal};

  // Expected control word per state, transcribed from the state table.
  function automatic ctl_t ew(input int s, input logic [2:0] alu = 3'b010, input logic cond = 1'b0);
    ctl_t e = '0;
    e.illegal = ill_exp;
    case (s)
      T_FETCH: begin e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.alu_src = 2'b01; e.alu_ctrl = 3'b010; end
      T_FWAIT: begin e.mem_read = 1; e.alu_src = 2'b01; e.alu_ctrl = 3'b010; end
      T_DEC:   begin e.alu_src = 2'b11; e.alu_ctrl = 3'b010; end
      T_REX:   begin e.alu_src_a = 1; e.alu_src = 2'b00; e.alu_ctrl = alu; end
      T_RWB:   begin e.reg_dst = 2'b01; e.reg_write = 1; e.instr_done = 1; end
      T_MADDR: begin e.alu_src_a = 1; e.alu_src = 2'b10; e.alu_ctrl = 3'b010; end
      T_MRD:   begin e.i_or_d = 1; e.mem_read = 1; end
      T_MWB:   begin e.data_to_write = 2'b01; e.mem_to_reg = 1; e.reg_write = 1; e.instr_done = 1; end
      T_MWR:   begin e.i_or_d = 1; e.mem_write = 1; e.instr_done = 1; end
      T_BR:    begin e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 1; e.pc_write_cond = cond; e.instr_done = 1; end
      T_IEX:   begin e.alu_src_a = 1; e.alu_src = 2'b10; e.alu_ctrl = alu; end
      T_IWB:   begin e.reg_write = 1; e.instr_done = 1; end
      T_J:     begin e.jmp = 1; e.pc_write = 1; e.instr_done = 1; end
      T_JAL:   begin e.jmp = 1; e.pc_write = 1; e.reg_dst = 2'b10; e.data_to_write = 2'b10; e.reg_write = 1; e.instr_done = 1; end
      T_JR:    begin e.jr = 1; e.pc_write = 1; e.instr_done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input ctl_t a, input ctl_t e, input string tag);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, a, e);
    end
  endtask

  task automatic cyc(input ctl_t e, input string tag);
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.opcode = op;
    bus.func   = fn;
    bus.zero   = z;
  endtask

  // Monitor: every queued cycle is compared against the live outputs mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) chk(obs, sb.pop_front(), tq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.mem_ready = 1'b1;
    setin(6'b000000, 6'b100000, 1'b0);
    @(posedge clk); #1;
    cyc(ew(T_IDLE), "reset0"); cyc(ew(T_IDLE), "reset1"); cyc(ew(T_IDLE), "reset2");
    rst_n = 1'b1;
    cyc(ew(T_IDLE), "idle");

    cyc(ew(T_FETCH), "add.fetch"); cyc(ew(T_DEC), "add.dec");
    cyc(ew(T_REX, 3'b010), "add.ex"); cyc(ew(T_RWB), "add.wb");
    setin(6'b000000, 6'b100010, 1'b0);
    cyc(ew(T_FETCH), "sub.fetch"); cyc(ew(T_DEC), "sub.dec");
    cyc(ew(T_REX, 3'b110), "sub.ex"); cyc(ew(T_RWB), "sub.wb");
    setin(6'b000000, 6'b101010, 1'b0);
    cyc(ew(T_FETCH), "slt.fetch"); cyc(ew(T_DEC), "slt.dec");
    cyc(ew(T_REX, 3'b111), "slt.ex"); cyc(ew(T_RWB), "slt.wb");
    setin(6'b100011, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "lw.fetch"); cyc(ew(T_DEC), "lw.dec"); cyc(ew(T_MADDR), "lw.addr");
    cyc(ew(T_MRD), "lw.rd"); cyc(ew(T_MWB), "lw.wb");
    setin(6'b101011, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "sw.fetch"); cyc(ew(T_DEC), "sw.dec"); cyc(ew(T_MADDR), "sw.addr");
    cyc(ew(T_MWR), "sw.wr");
    setin(6'b000100, 6'b000000, 1'b1);
    cyc(ew(T_FETCH), "beq1.fetch"); cyc(ew(T_DEC), "beq1.dec"); cyc(ew(T_BR, 3'b110, 1'b1), "beq_z1.br");
    setin(6'b000100, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "beq0.fetch"); cyc(ew(T_DEC), "beq0.dec"); cyc(ew(T_BR, 3'b110, 1'b0), "beq_z0.br");
    setin(6'b000101, 6'b000000, 1'b1);
    cyc(ew(T_FETCH), "bne1.fetch"); cyc(ew(T_DEC), "bne1.dec"); cyc(ew(T_BR, 3'b110, 1'b0), "bne_z1.br");
    setin(6'b000101, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "bne0.fetch"); cyc(ew(T_DEC), "bne0.dec"); cyc(ew(T_BR, 3'b110, 1'b1), "bne_z0.br");
    setin(6'b001000, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "addi.fetch"); cyc(ew(T_DEC), "addi.dec");
    cyc(ew(T_IEX, 3'b010), "addi.ex"); cyc(ew(T_IWB), "addi.wb");
    setin(6'b001010, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "slti.fetch"); cyc(ew(T_DEC), "slti.dec");
    cyc(ew(T_IEX, 3'b111), "slti.ex"); cyc(ew(T_IWB), "slti.wb");
    setin(6'b000010, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "j.fetch"); cyc(ew(T_DEC), "j.dec"); cyc(ew(T_J), "j.jump");
    setin(6'b000011, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "jal.fetch"); cyc(ew(T_DEC), "jal.dec"); cyc(ew(T_JAL), "jal.jal");
    setin(6'b000000, 6'b001000, 1'b0);
    cyc(ew(T_FETCH), "jr.fetch"); cyc(ew(T_DEC), "jr.dec"); cyc(ew(T_JR), "jr.jr");

    // Unsupported funct: aborts after RTYPE_EX and raises the sticky flag.
    setin(6'b000000, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "badfn.fetch"); cyc(ew(T_DEC), "badfn.dec"); cyc(ew(T_REX, 3'b000), "badfn.ex");
    ill_exp = 1'b1;
    setin(6'b000000, 6'b100100, 1'b0);
    cyc(ew(T_FETCH), "and.fetch"); cyc(ew(T_DEC), "and.dec");
    cyc(ew(T_REX, 3'b000), "and.ex"); cyc(ew(T_RWB), "and.wb");
    setin(6'b000000, 6'b100101, 1'b0);
    cyc(ew(T_FETCH), "or.fetch"); cyc(ew(T_DEC), "or.dec");
    cyc(ew(T_REX, 3'b001), "or.ex"); cyc(ew(T_RWB), "or.wb");

    // Reset asserted mid-way through MEM_WR must kill mem_write without waiting for a clock.
    setin(6'b101011, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "sw2.fetch"); cyc(ew(T_DEC), "sw2.dec"); cyc(ew(T_MADDR), "sw2.addr");
    sb.push_back(ew(T_MWR)); tq.push_back("sw2.wr");
    @(negedge clk); #2;
    rst_n   = 1'b0;
    ill_exp = 1'b0;
    #1;
    chk(obs, ew(T_IDLE), "rst.async");
    @(posedge clk); #1;
    cyc(ew(T_IDLE), "rst.hold0"); cyc(ew(T_IDLE), "rst.hold1");
    rst_n = 1'b1;
    cyc(ew(T_IDLE), "idle2");

    setin(6'b111111, 6'b000000, 1'b0);
    cyc(ew(T_FETCH), "badop.fetch"); cyc(ew(T_DEC), "badop.dec");
    ill_exp = 1'b1;
    setin(6'b000000, 6'b100000, 1'b0);
    cyc(ew(T_FETCH), "add2.fetch"); cyc(ew(T_DEC), "add2.dec");
    cyc(ew(T_REX, 3'b010), "add2.ex"); cyc(ew(T_RWB), "add2.wb");

`ifdef MC_MEM_WAIT_EN
    setin(6'b000010, 6'b000000, 1'b0);
    bus.mem_ready = 1'b0;
    cyc(ew(T_FWAIT), "wait.fetch0"); cyc(ew(T_FWAIT), "wait.fetch1"); cyc(ew(T_FWAIT), "wait.fetch2");
    bus.mem_ready = 1'b1;
    cyc(ew(T_FETCH), "wait.fetch_rdy"); cyc(ew(T_DEC), "wait.dec"); cyc(ew(T_J), "wait.jump");
`endif

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
